pstage_mdu: RTL and testbench
=============================

# pstage_mdu

Parametrised multiply/divide unit that sits beside the E-stage ALU and owns the HI/LO register pair. It accepts one operation per Start pulse, runs it for a configurable number of cycles while holding Busy, and commits the result to HI/LO. The hazard unit stalls the D stage on any HI/LO-dependent instruction while Start or Busy is high.

## Interface
- DATA_W, 32: operand and HI/LO width; must be even and ≥ 8.
- MULT_CYC, 5: cycles from Start to HI/LO commit for mult/multu; must be ≥ 1.
- DIV_CYC, 10: cycles from Start to HI/LO commit for div/divu; must be ≥ 1.

- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  qualifies MDOp/Data1/Data2 this cycle.
- MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-ops.
- Data1  input  DATA_W  rs operand, already forwarded.
- Data2  input  DATA_W  rt operand, already forwarded.
- Flush  input  1  abort the in-flight operation. Present only with MDU_FLUSH_EN.
- Busy  output  1  high while an operation is in flight; registered.
- HI  output  DATA_W  HI register; registered.
- LO  output  DATA_W  LO register; registered.

## Operation
- States: IDLE, MULT, DIV. Down-counter width is clog2(max(MULT_CYC, DIV_CYC)) + 1.
- Reset low: state IDLE, Busy 0, HI 0, LO 0, counter 0, latched operands 0. Takes effect immediately, including mid-operation.
- IDLE with Start and MDOp 0/1: latch operands, go to MULT, counter = MULT_CYC−1, Busy 1.
- IDLE with Start and MDOp 2/3: latch operands, go to DIV, counter = DIV_CYC−1, Busy 1.
- IDLE with Start and MDOp 4: HI ← Data1 at that edge. Busy stays 0.
- IDLE with Start and MDOp 5: LO ← Data1 at that edge. Busy stays 0.
- MULT/DIV with counter ≠ 0: decrement the counter.
- MULT/DIV with counter = 0: commit HI/LO, return to IDLE, Busy 0, all at the same edge.
- Start while Busy: ignored for every MDOp, including mthi/mtlo. The inputs are not queued.
- Start and the final commit in the same cycle: the commit happens; Start is ignored. Back-to-back issue therefore needs one IDLE cycle.
- mult: {HI,LO} = signed Data1 × signed Data2, 2·DATA_W-bit product. multu: the same, unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (div or divu): LO = all ones, HI = dividend.
- div overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- The result is computed from the operands latched at Start. Later changes to Data1/Data2 have no effect.

## Timing
- Start sampled at edge E0. Busy is 1 from after E0 until the commit edge E0+MULT_CYC (or E0+DIV_CYC).
- New HI/LO is visible in the cycle after the commit edge.
- Busy is therefore high for exactly MULT_CYC or DIV_CYC cycles.
- mthi/mtlo: one-edge latency, no Busy.
- HI/LO hold their values throughout an operation; there are no intermediate values.
- No combinational path from any input to any output.

## Configuration
- MDU_FLUSH_EN defined: Flush port exists.
  - Flush high at an edge while Busy: return to IDLE, Busy 0, HI/LO unchanged, counter 0.
  - Flush has priority over the commit in the same cycle; the commit is dropped.
  - Flush while IDLE blocks Start/mthi/mtlo that cycle.
- MDU_FLUSH_EN undefined: no Flush port. Every started operation runs to commit.

## Test plan
- Reset, then mult with Data1=0xFFFFFFFE (−2), Data2=3 → Busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with Data1=0xFFFFFFFF, Data2=2 → HI=0x00000001, LO=0xFFFFFFFE.
- div with −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles; div 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 5 ÷ 0 → LO=0xFFFFFFFF, HI=5. mthi 0x1234 during Busy → ignored; after commit, mthi 0x1234 → HI=0x1234 next cycle with Busy 0.
- Reset asserted mid-DIV at cycle 4 → Busy, HI, LO go to 0 immediately without waiting for the clock; Start after release runs normally.
- With MDU_FLUSH_EN: mult with HI/LO=0xAA/0xBB, Flush on the commit cycle → Busy 0, HI/LO remain 0xAA/0xBB.

Source files
------------

// File: rtl/pstage_mdu.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Optional feature macro: MDU_FLUSH_EN adds a Flush input that aborts the in-flight operation.
module pstage_mdu #(
  parameter int DATA_W   = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        MDOp,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
`ifdef MDU_FLUSH_EN
  input  logic              Flush,
`endif
  output logic              Busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]  a_reg, a_next;
  logic [DATA_W-1:0]  b_reg, b_next;
  logic               sgn_reg, sgn_next;
  logic               busy_reg, busy_next;
  logic [DATA_W-1:0]  hi_reg, hi_next;
  logic [DATA_W-1:0]  lo_reg, lo_next;
  logic               flush_req;

`ifdef MDU_FLUSH_EN
  assign flush_req = Flush;
`else
  assign flush_req = 1'b0;
`endif

  // Product of the latched operands; sign-extending to 2*DATA_W makes the
  // low 2*DATA_W bits of an unsigned multiply equal the signed product.
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, prod;

  assign mul_a_ext = sgn_reg ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg} : {{DATA_W{1'b0}}, a_reg};
  assign mul_b_ext = sgn_reg ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg} : {{DATA_W{1'b0}}, b_reg};
  assign prod      = mul_a_ext * mul_b_ext;

  // Signed divide via magnitudes. The most-negative / -1 case wraps back to
  // most-negative with a zero remainder, which is exactly the required result.
  logic              a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
  logic [DATA_W-1:0] div_hi, div_lo;

  assign a_neg  = sgn_reg & a_reg[DATA_W-1];
  assign b_neg  = sgn_reg & b_reg[DATA_W-1];
  assign a_mag  = a_neg ? (DATA_W'(0) - a_reg) : a_reg;
  assign b_mag  = b_neg ? (DATA_W'(0) - b_reg) : b_reg;
  assign b_zero = (b_reg == '0);
  assign b_div  = b_zero ? DATA_W'(1) : b_mag;
  assign q_mag  = a_mag / b_div;
  assign r_mag  = a_mag % b_div;
  assign quot   = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
  assign rem    = a_neg ? (DATA_W'(0) - r_mag) : r_mag;
  assign div_hi = b_zero ? a_reg : rem;
  assign div_lo = b_zero ? '1 : quot;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      busy_reg  <= busy_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;

    case (state_reg)
      S_IDLE: begin
        if (Start && !flush_req) begin
          case (MDOp)
            3'd0, 3'd1: begin
              a_next     = Data1;
              b_next     = Data2;
              sgn_next   = ~MDOp[0];
              cnt_next   = CNT_W'(MULT_CYC - 1);
              state_next = S_MULT;
            end
            3'd2, 3'd3: begin
              a_next     = Data1;
              b_next     = Data2;
              sgn_next   = ~MDOp[0];
              cnt_next   = CNT_W'(DIV_CYC - 1);
              state_next = S_DIV;
            end
            3'd4:    hi_next = Data1;
            3'd5:    lo_next = Data1;
            default: ;
          endcase
        end
      end

      S_MULT, S_DIV: begin
        // Abort wins over the commit that would happen this edge.
        if (flush_req) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          if (state_reg == S_MULT) begin
            hi_next = prod[2*DATA_W-1:DATA_W];
            lo_next = prod[DATA_W-1:0];
          end else begin
            hi_next = div_hi;
            lo_next = div_lo;
          end
          state_next = S_IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  assign Busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_pstage_mdu.sv
// Randomised self-checking bench for pstage_mdu against a behavioural HI/LO model.
// Flush scenarios are compiled in when MDU_FLUSH_EN is defined.
module tb_pstage_mdu;

  localparam int DATA_W   = 32;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic              clk;
  logic              reset;
  logic              start;
  logic [2:0]        md_op;
  logic [DATA_W-1:0] data1, data2;
`ifdef MDU_FLUSH_EN
  logic              flush;
`endif
  logic              busy;
  logic [DATA_W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hi_m, lo_m;

  pstage_mdu #(
    .DATA_W  (DATA_W),
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .Start(start),
    .MDOp (md_op),
    .Data1(data1),
    .Data2(data2),
`ifdef MDU_FLUSH_EN
    .Flush(flush),
`endif
    .Busy (busy),
    .HI   (hi),
    .LO   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted operation, straight from the arithmetic rules.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    case (op)
      3'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = ps;
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = pu;
      end
      3'd2: begin
        if (b == 32'd0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 32'd0;
        end else begin
          lo_m = $signed(a) / $signed(b);
          hi_m = $signed(a) % $signed(b);
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = a;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      3'd4:    hi_m = a;
      3'd5:    lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic [2:0] op);
    if (op <= 3'd1) return MULT_CYC;
    if (op <= 3'd3) return DIV_CYC;
    return 0;
  endfunction

  // Issue one op; while busy, scramble the operand inputs and optionally
  // pulse Start with an mthi on busy cycle 'poke' (must be ignored).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = op; data1 = a; data2 = b;
    model_op(op, a, b);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      n++;
      start = (i == poke);
      md_op = 3'd4;
      data1 = (i == poke) ? 32'h0000_1234 : $urandom;
      data2 = $urandom;
    end
    start = 1'b0;
    $display("[TB] op=%0d a=0x%08h b=0x%08h busy=%0d HI=0x%08h LO=0x%08h", op, a, b, n, hi, lo);
    check("busy_cycles", 64'(n), 64'(busy_len(op)));
    check("hi", {32'd0, hi}, {32'd0, hi_m});
    check("lo", {32'd0, lo}, {32'd0, lo_m});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; data1 = '0; data2 = '0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    hi_m = '0; lo_m = '0;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, MULT_CYC - 1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DIV_CYC - 1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, -1);
    run_op(3'd3, 32'd5, 32'd0, 3);
    run_op(3'd4, 32'h0000_1234, 32'd0, -1);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, -1);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1);

    for (int k = 0; k < 24; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_op(op, pick_val(), pick_val(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
    end

    // Asynchronous reset in the middle of a divide.
    run_op(3'd5, 32'h0BAD_CAFE, 32'd0, -1);
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; data1 = 32'd100; data2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    $display("[TB] async reset mid-div busy=%0b HI=0x%08h LO=0x%08h", busy, hi, lo);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_hi", {32'd0, hi}, 64'd0);
    check("async_rst_lo", {32'd0, lo}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, -1);

`ifdef MDU_FLUSH_EN
    run_op(3'd4, 32'h0000_00AA, 32'd0, -1);
    run_op(3'd5, 32'h0000_00BB, 32'd0, -1);
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; data1 = 32'd3; data2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (MULT_CYC - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    $display("[TB] flush on commit busy=%0b HI=0x%08h LO=0x%08h", busy, hi, lo);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h0000_00AA);
    check("flush_lo", {32'd0, lo}, 64'h0000_00BB);
    flush = 1'b1; start = 1'b1; md_op = 3'd4; data1 = 32'h55;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    $display("[TB] flush blocks mthi HI=0x%08h", hi);
    check("flush_idle_hi", {32'd0, hi}, 64'h0000_00AA);
    hi_m = 32'h0000_00AA; lo_m = 32'h0000_00BB;
    run_op(3'd3, 32'd100, 32'd7, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
